cpu_sequencer: RTL and testbench

- Fetch/decode/execute controller for the 8-bit accumulator CPU.
- Sits directly upstream of the memory unit, program counter, ALU and accumulator register, and drives all of their strobes.
- Fetches 1- or 2-byte instructions from synchronous-read memory, then sequences PC, memory, ALU and accumulator to execute them.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_opcode_decoder.sv | 43 ++++
 rtl/cpu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, ALU op codes
// and sequencer states.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    // Explicit encodings keep the legacy state values visible.
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        OPERAND = 3'd2,
        EXEC    = 3'd3,
        HALT    = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_opcode_decoder.sv
// Combinational opcode classifier: instruction length, execute phase,
// ALU operation and illegal-opcode detection.
module cpu_opcode_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic       is_two_byte_o,
    output logic       needs_exec_o,
    output logic       is_alu_o,
    output logic [3:0] alu_op_o,
    output logic       illegal_o
);

    always_comb begin
        is_two_byte_o = 1'b0;
        needs_exec_o  = 1'b0;
        is_alu_o      = 1'b0;
        alu_op_o      = '0;
        illegal_o     = 1'b0;
        unique case (opcode_i)
            OP_NOP, OP_HLT: ;
            OP_LDI, OP_STA, OP_JMP, OP_JZ: is_two_byte_o = 1'b1;
            OP_LDA: begin
                is_two_byte_o = 1'b1;
                needs_exec_o  = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                is_two_byte_o = 1'b1;
                needs_exec_o  = 1'b1;
                is_alu_o      = 1'b1;
                unique case (opcode_i)
                    OP_ADD:  alu_op_o = ALU_ADD;
                    OP_SUB:  alu_op_o = ALU_SUB;
                    OP_AND:  alu_op_o = ALU_AND;
                    OP_OR:   alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_XOR;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller: sequences PC, memory, ALU and
// accumulator strobes for 1- and 2-byte instructions.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [ADDR_WIDTH-1:0] pc_value,
    output logic                  pc_load,
    output logic                  pc_increment,
    output logic [ADDR_WIDTH-1:0] pc_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] acc_value,
    output logic                  acc_load,
    output logic [DATA_WIDTH-1:0] acc_data,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  halted,
    output logic                  illegal_op
);

    state_t     state_q, state_d;
    logic [3:0] ir_q, ir_d;
    logic       z_q, z_d;

    logic [3:0] opcode;
    logic       is_two_byte, needs_exec, is_alu, illegal;
    logic [3:0] dec_alu_op;

    logic                  pc_load_c, pc_inc_c, mem_we_c, acc_load_c, halted_c, illegal_c;
    logic [ADDR_WIDTH-1:0] pc_data_c, mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c, acc_data_c, alu_a_c, alu_b_c;
    logic [3:0]            alu_op_c;

    // In DECODE the instruction byte is still on mem_rdata; ir is not yet loaded.
    assign opcode = (state_q == DECODE) ? mem_rdata[7:4] : ir_q;

    cpu_opcode_decoder u_decoder (
        .opcode_i      (opcode),
        .is_two_byte_o (is_two_byte),
        .needs_exec_o  (needs_exec),
        .is_alu_o      (is_alu),
        .alu_op_o      (dec_alu_op),
        .illegal_o     (illegal)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        z_d         = z_q;
        pc_load_c   = 1'b0;
        pc_inc_c    = 1'b0;
        pc_data_c   = '0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_we_c    = 1'b0;
        acc_load_c  = 1'b0;
        acc_data_c  = '0;
        alu_a_c     = '0;
        alu_b_c     = '0;
        alu_op_c    = '0;
        halted_c    = 1'b0;
        illegal_c   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (run) begin
                    mem_addr_c = pc_value;
                    pc_inc_c   = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                ir_d = mem_rdata[7:4];
                if (opcode == OP_HLT) begin
                    state_d = HALT;
                end else if (illegal) begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end else if (is_two_byte) begin
                    mem_addr_c = pc_value;
                    pc_inc_c   = 1'b1;
                    state_d    = OPERAND;
                end else begin
                    state_d = FETCH;
                end
            end
            OPERAND: begin
                state_d = FETCH;
                unique case (ir_q)
                    OP_LDI: begin
                        acc_load_c = 1'b1;
                        acc_data_c = mem_rdata;
                    end
                    OP_JMP: begin
                        pc_load_c = 1'b1;
                        pc_data_c = ADDR_WIDTH'(mem_rdata);
                    end
                    OP_JZ: begin
                        pc_load_c = z_q;
                        pc_data_c = ADDR_WIDTH'(mem_rdata);
                    end
                    OP_STA: begin
                        mem_addr_c  = ADDR_WIDTH'(mem_rdata);
                        mem_we_c    = 1'b1;
                        mem_wdata_c = acc_value;
                    end
                    default: begin
                        if (needs_exec) begin
                            mem_addr_c = ADDR_WIDTH'(mem_rdata);
                            state_d    = EXEC;
                        end
                    end
                endcase
            end
            EXEC: begin
                acc_load_c = 1'b1;
                if (is_alu) begin
                    alu_a_c    = acc_value;
                    alu_b_c    = mem_rdata;
                    alu_op_c   = dec_alu_op;
                    acc_data_c = alu_result;
                end else begin
                    acc_data_c = mem_rdata;
                end
                state_d = FETCH;
            end
            HALT: halted_c = 1'b1;
            default: state_d = FETCH;
        endcase
        if (acc_load_c) begin
            z_d = (acc_data_c == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
        end
    end

    // Reset masks every output immediately, before the async clear settles.
    always_comb begin
        pc_load      = pc_load_c & ~reset;
        pc_increment = pc_inc_c & ~reset;
        pc_data      = reset ? '0 : pc_data_c;
        mem_address  = reset ? '0 : mem_addr_c;
        mem_wdata    = reset ? '0 : mem_wdata_c;
        mem_we       = mem_we_c & ~reset;
        acc_load     = acc_load_c & ~reset;
        acc_data     = reset ? '0 : acc_data_c;
        alu_a        = reset ? '0 : alu_a_c;
        alu_b        = reset ? '0 : alu_b_c;
        alu_op       = reset ? '0 : alu_op_c;
        halted       = halted_c & ~reset;
        illegal_op   = illegal_c & ~reset;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer with behavioural memory, PC, accumulator and ALU;
// accumulator loads and stores are checked against a scoreboard.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [7:0] pc_value, pc_data, mem_address, mem_rdata, mem_wdata;
    logic [7:0] acc_value = 8'h00;
    logic [7:0] acc_data, alu_a, alu_b, alu_result;
    logic       pc_load, pc_increment, mem_we, acc_load, halted, illegal_op;
    logic [3:0] alu_op;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [256];
    logic        ld_en = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  ld_addr = 8'h00;
    logic [7:0]  ld_data = 8'h00;
    logic [7:0]  exp_acc [$];
    logic [15:0] exp_wr [$];
    logic [7:0]  sb_e;
    logic [15:0] sb_w;

    always #5 clk = ~clk;

    cpu_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .pc_value     (pc_value),
        .pc_load      (pc_load),
        .pc_increment (pc_increment),
        .pc_data      (pc_data),
        .mem_address  (mem_address),
        .mem_rdata    (mem_rdata),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .acc_value    (acc_value),
        .acc_load     (acc_load),
        .acc_data     (acc_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .halted       (halted),
        .illegal_op   (illegal_op)
    );

    // Surrounding datapath
    always @(posedge clk) begin
        mem_rdata <= mem[mem_address];
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[mem_address] <= mem_wdata;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) pc_value <= 8'h00;
        else if (pc_load) pc_value <= pc_data;
        else if (pc_increment) pc_value <= pc_value + 8'd1;
    end

    always @(posedge clk) begin
        if (acc_load) acc_value <= acc_data;
    end

    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    // Scoreboard consumer: every accumulator load and store must match the next expected entry.
    always @(negedge clk) begin
        #2;
        if (!reset && acc_load) begin
            total++;
            if (exp_acc.size() == 0) begin
                bad++;
                $display("FAIL sb_acc unexpected load got=%h exp=none", acc_data);
            end else begin
                sb_e = exp_acc.pop_front();
                if (acc_data !== sb_e) begin
                    bad++;
                    $display("FAIL sb_acc got=%h exp=%h", acc_data, sb_e);
                end
            end
        end
        if (!reset && mem_we) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL sb_store unexpected got=%h/%h exp=none", mem_address, mem_wdata);
            end else begin
                sb_w = exp_wr.pop_front();
                if ({mem_address, mem_wdata} !== sb_w) begin
                    bad++;
                    $display("FAIL sb_store got=%h/%h exp=%h/%h",
                             mem_address, mem_wdata, sb_w[15:8], sb_w[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic begin_reset();
        reset = 1'b1;
        exp_acc.delete();
        exp_wr.delete();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        begin_reset();
        run = 1'b1;
        poke(8'h00, 8'h00);
        poke(8'h01, 8'hF0);
        tick();
        total++;
        if ({pc_load, pc_increment, mem_we, acc_load, halted, illegal_op} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b exp=000000",
                     {pc_load, pc_increment, mem_we, acc_load, halted, illegal_op});
        end
        run = 1'b0;
        release_reset();
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({pc_increment, pc_load, mem_we, acc_load} !== 4'b0) begin
                bad++;
                $display("FAIL run_low_idle got=%b exp=0000", {pc_increment, pc_load, mem_we, acc_load});
            end
            tick();
        end
        run = 1'b1;
        #1;
        total++;
        if (mem_address !== 8'h00 || pc_increment !== 1'b1) begin
            bad++;
            $display("FAIL fetch0 got=%h/%b exp=00/1", mem_address, pc_increment);
        end
        tick();
        total++;
        if ({pc_increment, pc_load, mem_we, acc_load, illegal_op, halted} !== 6'b0) begin
            bad++;
            $display("FAIL nop_decode got=%b exp=000000",
                     {pc_increment, pc_load, mem_we, acc_load, illegal_op, halted});
        end
        tick();
        total++;
        if (mem_address !== 8'h01 || pc_increment !== 1'b1) begin
            bad++;
            $display("FAIL nop_refetch got=%h/%b exp=01/1", mem_address, pc_increment);
        end
    endtask

    task automatic test_program();
        int n;
        begin_reset();
        poke(8'h00, 8'h10);
        poke(8'h01, 8'h2A);
        poke(8'h02, 8'h30);
        poke(8'h03, 8'h80);
        poke(8'h04, 8'hF0);
        exp_acc.push_back(8'h2A);
        exp_wr.push_back({8'h80, 8'h2A});
        release_reset();
        n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL halt_latency got=%0d exp=8", n);
        end
        total++;
        if (mem[8'h80] !== 8'h2A) begin
            bad++;
            $display("FAIL sta_mem got=%h exp=2a", mem[8'h80]);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (halted !== 1'b1 || {pc_increment, pc_load, mem_we, acc_load, illegal_op} !== 5'b0) begin
                bad++;
                $display("FAIL halt_hold got=%b/%b exp=1/00000", halted,
                         {pc_increment, pc_load, mem_we, acc_load, illegal_op});
            end
        end
        total++;
        if (exp_acc.size() != 0 || exp_wr.size() != 0) begin
            bad++;
            $display("FAIL program_sb_left got=%0d/%0d exp=0/0", exp_acc.size(), exp_wr.size());
        end
    endtask

    task automatic test_sub_jz();
        begin_reset();
        poke(8'h00, 8'h10); poke(8'h01, 8'h05);
        poke(8'h02, 8'h50); poke(8'h03, 8'h81);
        poke(8'h04, 8'hA0); poke(8'h05, 8'h40);
        poke(8'h40, 8'hF0); poke(8'h81, 8'h05);
        exp_acc.push_back(8'h05);
        exp_acc.push_back(8'h00);
        release_reset();
        for (int c = 1; c <= 11; c++) begin
            if (c == 7) begin
                total++;
                if (alu_op !== 4'd1 || alu_a !== 8'h05 || alu_b !== 8'h05 || acc_data !== 8'h00) begin
                    bad++;
                    $display("FAIL sub_exec got=%h/%h/%h/%h exp=1/05/05/00", alu_op, alu_a, alu_b, acc_data);
                end
            end
            if (c == 10) begin
                total++;
                if (pc_load !== 1'b1 || pc_data !== 8'h40 || pc_increment !== 1'b0) begin
                    bad++;
                    $display("FAIL jz_taken got=%b/%h/%b exp=1/40/0", pc_load, pc_data, pc_increment);
                end
            end
            if (c == 11) begin
                total++;
                if (mem_address !== 8'h40) begin
                    bad++;
                    $display("FAIL jz_target got=%h exp=40", mem_address);
                end
            end
            if (c < 11) tick();
        end
        total++;
        if (exp_acc.size() != 0) begin
            bad++;
            $display("FAIL sub_sb_left got=%0d exp=0", exp_acc.size());
        end
    endtask

    task automatic test_jz_not_taken();
        int loads;
        begin_reset();
        poke(8'h00, 8'h10); poke(8'h01, 8'h01);
        poke(8'h02, 8'hA0); poke(8'h03, 8'h40);
        poke(8'h04, 8'hF0);
        exp_acc.push_back(8'h01);
        release_reset();
        loads = 0;
        for (int c = 1; c <= 7; c++) begin
            if (pc_load === 1'b1) loads++;
            if (c == 7) begin
                total++;
                if (mem_address !== 8'h04 || pc_increment !== 1'b1) begin
                    bad++;
                    $display("FAIL jz_fallthrough got=%h/%b exp=04/1", mem_address, pc_increment);
                end
            end
            if (c < 7) tick();
        end
        total++;
        if (loads !== 0) begin
            bad++;
            $display("FAIL jz_no_load got=%0d exp=0", loads);
        end
    endtask

    task automatic test_illegal();
        int pulses;
        begin_reset();
        poke(8'h00, 8'hC0);
        poke(8'h01, 8'hF0);
        release_reset();
        pulses = 0;
        for (int c = 1; c <= 5; c++) begin
            if (illegal_op === 1'b1) pulses++;
            if (c == 2) begin
                total++;
                if (illegal_op !== 1'b1 || {pc_increment, pc_load, mem_we, acc_load, halted} !== 5'b0) begin
                    bad++;
                    $display("FAIL illegal_decode got=%b/%b exp=1/00000", illegal_op,
                             {pc_increment, pc_load, mem_we, acc_load, halted});
                end
            end
            if (c == 3) begin
                total++;
                if (mem_address !== 8'h01 || pc_increment !== 1'b1) begin
                    bad++;
                    $display("FAIL illegal_next got=%h/%b exp=01/1", mem_address, pc_increment);
                end
            end
            tick();
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL illegal_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_pc_wrap();
        begin_reset();
        poke(8'h00, 8'h07);
        poke(8'h01, 8'h90);
        poke(8'h02, 8'hFF);
        poke(8'hFF, 8'h10);
        exp_acc.push_back(8'h07);
        release_reset();
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) begin
                total++;
                if (pc_load !== 1'b1 || pc_data !== 8'hFF) begin
                    bad++;
                    $display("FAIL jmp_ff got=%b/%h exp=1/ff", pc_load, pc_data);
                end
            end
            if (c == 7) begin
                total++;
                if (mem_address !== 8'h00 || pc_increment !== 1'b1) begin
                    bad++;
                    $display("FAIL wrap_operand got=%h/%b exp=00/1", mem_address, pc_increment);
                end
            end
            if (c == 9) begin
                total++;
                if (mem_address !== 8'h01) begin
                    bad++;
                    $display("FAIL wrap_next got=%h exp=01", mem_address);
                end
            end
            if (c < 9) tick();
        end
        total++;
        if (exp_acc.size() != 0) begin
            bad++;
            $display("FAIL wrap_sb_left got=%0d exp=0", exp_acc.size());
        end
    endtask

    task automatic test_reset_exec();
        begin_reset();
        poke(8'h00, 8'h10); poke(8'h01, 8'h03);
        poke(8'h02, 8'h40); poke(8'h03, 8'h90);
        poke(8'h90, 8'h04);
        exp_acc.push_back(8'h03);
        release_reset();
        for (int c = 1; c < 7; c++) tick();
        reset = 1'b1;
        #1;
        total++;
        if ({acc_load, mem_we, pc_load, pc_increment, halted} !== 5'b0) begin
            bad++;
            $display("FAIL reset_exec_strobes got=%b exp=00000",
                     {acc_load, mem_we, pc_load, pc_increment, halted});
        end
        tick();
        tick();
        total++;
        if (acc_value !== 8'h03) begin
            bad++;
            $display("FAIL reset_exec_acc got=%h exp=03", acc_value);
        end
        reset = 1'b0;
        #1;
        total++;
        if (halted !== 1'b0 || mem_address !== 8'h00 || pc_increment !== 1'b1) begin
            bad++;
            $display("FAIL reset_exec_fetch got=%b/%h/%b exp=0/00/1", halted, mem_address, pc_increment);
        end
        total++;
        if (exp_acc.size() != 0) begin
            bad++;
            $display("FAIL reset_exec_sb_left got=%0d exp=0", exp_acc.size());
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_sub_jz();
        test_jz_not_taken();
        test_illegal();
        test_pc_wrap();
        test_reset_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
